divider_sequencer: RTL
======================

// Module: divider_sequencer
// PURPOSE
//  Multi-cycle controller that time-multiplexes a K-iteration restoring-division step chain to produce
//  RISC-V DIV/DIVU/REM/REMU results. Replaces the fully unrolled 32-stage divider where area matters.
//  Sits between decode/issue (request side) and writeback (response side).
//  Uses a valid/ready handshake on both sides; one operation in flight at a time.
// PARAMETERS
//  ITERS_PER_CYCLE  4   division iterations per BUSY cycle; legal values 1,2,4,8 (must divide 32)
//  TAG_W            5   width of opaque tag (e.g. rd index) carried from request to response
// PORTS
//  clk          in   1       rising-edge clock
//  rst_n        in   1       synchronous, active-low reset
//  i_flush      in   1       abort in-flight op; drop held result
//  i_valid      in   1       request valid
//  o_ready      out  1       request ready (=1 only in IDLE)
//  i_op         in   2       div_pkg::div_op_e: DIV=0, DIVU=1, REM=2, REMU=3
//  i_dividend   in   32      rs1
//  i_divisor    in   32      rs2
//  i_tag        in   TAG_W   opaque tag
//  o_valid      out  1       response valid
//  i_ready      in   1       response consumed
//  o_result     out  32      quotient for DIV/DIVU, remainder for REM/REMU
//  o_tag        out  TAG_W   tag of the completing request
// BEHAVIOUR
//  - Reset (rst_n=0 at a clk edge): state=IDLE, o_valid=0, o_result=0, o_tag=0, counter=0; o_ready=1 after reset.
//  - accept = i_valid & o_ready & ~i_flush. All inputs are latched on accept.
//  - FSM IDLE->BUSY on accept (normal case); IDLE->DONE on accept for special cases; BUSY->DONE after
//    N=32/ITERS_PER_CYCLE BUSY cycles; DONE->IDLE when i_ready=1. DONE holds o_result/o_tag stable while i_ready=0.
//  - o_valid=1 iff state==DONE. Latency: o_valid rises N edges after the accept edge (K=4: 8), 1 edge for special cases.
//  - Signed ops (DIV, REM): absolute values of the operands are latched on accept. The unsigned step chain runs on magnitudes.
//    quotient is negated iff the operand signs differ; remainder takes the sign of the dividend. Fixup is combinational in DONE.
//  - Step chain per cycle: K chained iterations; r'=(r<<1)|dvd[31]; if r'>=dvs then r'-=dvs, q=(q<<1)|1, else q<<=1; dvd<<=1.
//    All arithmetic is 32-bit unsigned; the compare is unsigned; abs(-2^31)=0x8000_0000 is treated as unsigned.
//  - Special cases bypass BUSY:
//    * divisor==0: quotient=0xFFFF_FFFF (DIV and DIVU); remainder=dividend.
//    * DIV/REM with 0x8000_0000 / 0xFFFF_FFFF: quotient=0x8000_0000, remainder=0.
//  - i_flush (any state, priority below reset): next state IDLE, o_valid=0 next cycle, result discarded.
//    A request presented with i_flush in the same cycle is NOT accepted.
//  - No overlap: a new request can be accepted no earlier than the cycle after DONE->IDLE (one bubble per op).
//  - Iteration counter: $clog2(N)+1 bits; cleared on accept; it does not wrap (BUSY exits at count==N-1).
// STRUCTURE
//  - div_pkg: div_op_e enum, div_state_e {IDLE,BUSY,DONE}, localparams XLEN=32, INT_MIN=32'h8000_0000, ALL_ONES.
//  - Sub-module divider_iter_chain #(K): combinational; K chained single iterations;
//    in/out {dividend, remainder, quotient}, divisor.
//  - Top: FSM, operand/sign/tag registers, counter, special-case detect, output sign fixup and mux.
// TESTING
//  1. DIVU 100/7, K=4 -> o_valid exactly 8 edges after accept, o_result=14; REMU same operands -> 2.
//  2. DIV -7/2 -> 0xFFFF_FFFD (-3); REM -7/2 -> 0xFFFF_FFFF (-1); DIV 7/-2 -> -3; REM 7/-2 -> 1.
//  3. DIVU 5/0 -> 0xFFFF_FFFF; REM 5/0 -> 5. Both o_valid 1 edge after accept, with no BUSY cycles.
//  4. DIV 0x8000_0000/0xFFFF_FFFF -> 0x8000_0000; REM same operands -> 0. DIVU 0x8000_0000/1 -> 0x8000_0000 via BUSY.
//  5. Backpressure: hold i_ready=0 for 5 cycles in DONE -> o_result and o_tag stable, o_ready=0.
//     Raise i_ready -> IDLE next edge, o_ready=1.
//  6. Assert i_flush at BUSY cycle 3 -> IDLE, no o_valid. i_valid+i_flush together -> no accept.
//     rst_n=0 mid-BUSY -> all outputs zero and o_ready=1. Random DIV/DIVU/REM/REMU vs C model, K in {1,2,4,8}.

Source files
------------

// File: rtl/div_pkg.sv
// Shared types and constants for the multi-cycle RISC-V divider.
// Contents:
//   XLEN, INT_MIN, ALL_ONES  - datapath width and special operand values
//   div_op_e                 - DIV=0, DIVU=1, REM=2, REMU=3
//   div_state_e              - sequencer states IDLE, BUSY, DONE
//   abs_val()                - two's-complement magnitude when enabled
package div_pkg;

  localparam int          XLEN     = 32;
  localparam logic [31:0] INT_MIN  = 32'h8000_0000;
  localparam logic [31:0] ALL_ONES = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    DIV  = 2'd0,
    DIVU = 2'd1,
    REM  = 2'd2,
    REMU = 2'd3
  } div_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } div_state_e;

  // Magnitude of v when en is set; abs(INT_MIN) wraps to 0x8000_0000, which
  // is the correct magnitude once read as unsigned.
  function automatic logic [31:0] abs_val(input logic [31:0] v, input logic en);
    return (en && v[31]) ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/divider_sequencer_if.sv
// Request/response bundle of the divider sequencer.
// Signals:
//   i_flush                                   abort in-flight op, drop held result
//   i_valid/o_ready, i_op, i_dividend,
//   i_divisor, i_tag                          request channel
//   o_valid/i_ready, o_result, o_tag          response channel
// Modports: master = issue/writeback side, slave = divider.
interface divider_sequencer_if #(
  parameter int TAG_W = 5
);
  import div_pkg::*;

  logic             i_flush;
  logic             i_valid;
  logic             o_ready;
  div_op_e          i_op;
  logic [31:0]      i_dividend;
  logic [31:0]      i_divisor;
  logic [TAG_W-1:0] i_tag;
  logic             o_valid;
  logic             i_ready;
  logic [31:0]      o_result;
  logic [TAG_W-1:0] o_tag;

  modport master (
    output i_flush, i_valid, i_op, i_dividend, i_divisor, i_tag, i_ready,
    input  o_ready, o_valid, o_result, o_tag
  );

  modport slave (
    input  i_flush, i_valid, i_op, i_dividend, i_divisor, i_tag, i_ready,
    output o_ready, o_valid, o_result, o_tag
  );

endinterface

// File: rtl/divider_iter_chain.sv
// Combinational chain of K restoring-division iterations on unsigned operands.
// Ports:
//   dividend_in/out   dividend being shifted out MSB first
//   remainder_in/out  partial remainder
//   quotient_in/out   partial quotient, one bit shifted in per iteration
//   divisor           unsigned divisor (non-zero when used)
module divider_iter_chain #(
  parameter int K = 4
) (
  input  logic [31:0] dividend_in,
  input  logic [31:0] remainder_in,
  input  logic [31:0] quotient_in,
  input  logic [31:0] divisor,
  output logic [31:0] dividend_out,
  output logic [31:0] remainder_out,
  output logic [31:0] quotient_out
);

  logic [31:0] dvd [K+1];
  logic [31:0] rem [K+1];
  logic [31:0] quo [K+1];

  assign dvd[0] = dividend_in;
  assign rem[0] = remainder_in;
  assign quo[0] = quotient_in;

  for (genvar gi = 0; gi < K; gi++) begin : g_iter
    // The shifted remainder keeps its carry-out bit: with a divisor above
    // 2^31 the partial remainder can exceed 32 bits after the shift, and the
    // compare must see that bit to stay exact. The difference always fits in
    // 32 bits whenever the subtraction is taken.
    logic [32:0] shifted;
    logic        fits;

    assign shifted    = {rem[gi], dvd[gi][31]};
    assign fits       = (shifted >= {1'b0, divisor});
    assign rem[gi+1]  = fits ? (shifted[31:0] - divisor) : shifted[31:0];
    assign quo[gi+1]  = {quo[gi][30:0], fits};
    assign dvd[gi+1]  = {dvd[gi][30:0], 1'b0};
  end

  assign dividend_out  = dvd[K];
  assign remainder_out = rem[K];
  assign quotient_out  = quo[K];

endmodule

// File: rtl/divider_sequencer.sv
// Multi-cycle RISC-V DIV/DIVU/REM/REMU unit: runs ITERS_PER_CYCLE restoring
// iterations per BUSY cycle, one operation in flight, valid/ready on both sides.
// Ports:
//   clk    rising-edge clock
//   rst_n  synchronous active-low reset
//   bus    divider_sequencer_if.slave (request, response and flush)
module divider_sequencer
  import div_pkg::*;
#(
  parameter int ITERS_PER_CYCLE = 4,
  parameter int TAG_W           = 5
) (
  input logic                 clk,
  input logic                 rst_n,
  divider_sequencer_if.slave  bus
);

  localparam int              N     = XLEN / ITERS_PER_CYCLE;
  localparam int              CNT_W = $clog2(N) + 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);

  div_state_e       state_reg;
  logic [31:0]      dvd_reg;
  logic [31:0]      rem_reg;
  logic [31:0]      quo_reg;
  logic [31:0]      dvs_reg;
  logic             neg_q_reg;
  logic             neg_r_reg;
  logic             want_rem_reg;
  logic [TAG_W-1:0] tag_reg;
  logic [CNT_W-1:0] cnt_reg;

  logic        accept;
  logic        signed_op;
  logic        div_by_zero;
  logic        overflow;
  logic [31:0] abs_a;
  logic [31:0] abs_b;
  logic [31:0] chain_dvd;
  logic [31:0] chain_rem;
  logic [31:0] chain_quo;
  logic [31:0] q_fixed;
  logic [31:0] r_fixed;

  assign bus.o_ready = (state_reg == IDLE);
  assign bus.o_valid = (state_reg == DONE);

  assign accept      = bus.i_valid & bus.o_ready & ~bus.i_flush;
  assign signed_op   = (bus.i_op == DIV) || (bus.i_op == REM);
  assign div_by_zero = (bus.i_divisor == 32'd0);
  assign overflow    = signed_op && (bus.i_dividend == INT_MIN) && (bus.i_divisor == ALL_ONES);
  assign abs_a       = abs_val(bus.i_dividend, signed_op);
  assign abs_b       = abs_val(bus.i_divisor, signed_op);

  divider_iter_chain #(
    .K (ITERS_PER_CYCLE)
  ) u_chain (
    .dividend_in   (dvd_reg),
    .remainder_in  (rem_reg),
    .quotient_in   (quo_reg),
    .divisor       (dvs_reg),
    .dividend_out  (chain_dvd),
    .remainder_out (chain_rem),
    .quotient_out  (chain_quo)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      dvd_reg      <= '0;
      rem_reg      <= '0;
      quo_reg      <= '0;
      dvs_reg      <= '0;
      neg_q_reg    <= 1'b0;
      neg_r_reg    <= 1'b0;
      want_rem_reg <= 1'b0;
      tag_reg      <= '0;
      cnt_reg      <= '0;
    end else if (bus.i_flush) begin
      state_reg <= IDLE;
    end else begin
      case (state_reg)
        IDLE: begin
          if (accept) begin
            tag_reg      <= bus.i_tag;
            want_rem_reg <= bus.i_op[1];
            dvs_reg      <= abs_b;
            dvd_reg      <= abs_a;
            cnt_reg      <= '0;
            if (div_by_zero) begin
              // Final values are stored directly; no sign fixup applies.
              quo_reg   <= ALL_ONES;
              rem_reg   <= bus.i_dividend;
              neg_q_reg <= 1'b0;
              neg_r_reg <= 1'b0;
              state_reg <= DONE;
            end else if (overflow) begin
              quo_reg   <= INT_MIN;
              rem_reg   <= '0;
              neg_q_reg <= 1'b0;
              neg_r_reg <= 1'b0;
              state_reg <= DONE;
            end else begin
              quo_reg   <= '0;
              rem_reg   <= '0;
              neg_q_reg <= signed_op & (bus.i_dividend[31] ^ bus.i_divisor[31]);
              neg_r_reg <= signed_op & bus.i_dividend[31];
              state_reg <= BUSY;
            end
          end
        end
        BUSY: begin
          dvd_reg <= chain_dvd;
          rem_reg <= chain_rem;
          quo_reg <= chain_quo;
          // Counter runs 0..N-1 during BUSY and stops at N, so it never wraps.
          cnt_reg <= cnt_reg + CNT_W'(1);
          if (cnt_reg == LAST) begin
            state_reg <= DONE;
          end
        end
        DONE: begin
          if (bus.i_ready) begin
            state_reg <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  // Sign fixup on the held magnitudes; outputs read zero outside DONE.
  assign q_fixed      = neg_q_reg ? (~quo_reg + 32'd1) : quo_reg;
  assign r_fixed      = neg_r_reg ? (~rem_reg + 32'd1) : rem_reg;
  assign bus.o_result = (state_reg == DONE) ? (want_rem_reg ? r_fixed : q_fixed) : 32'd0;
  assign bus.o_tag    = (state_reg == DONE) ? tag_reg : '0;

endmodule
